ex_cdb_pipe: RTL and testbench

- Parametrised execute-to-complete pipeline for the out-of-order core.
- Accepts up to N_LANES issued results per cycle, carries each through a fixed LAT-stage execute latency, then arbitrates finished results onto N_CDB common-data-bus ports with round-robin fairness and per-lane backpressure.
- Replaces the single-cycle issue/ex latch plus implicit one-CDB-per-lane completion. Adds multi-cycle latency, fewer CDB ports than lanes, issue stall and branch flush.
- Sits between issue_stage and ROB/RS wakeup. inflight_count feeds RS order-index arithmetic.

---
 rtl/ex_cdb_pipe_pkg.sv | 33 +++
 rtl/ex_cdb_pipe_rr_multi_grant.sv | 36 +++
 rtl/ex_cdb_pipe.sv | 137 +++++++++++++
 tb/tb_ex_cdb_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_cdb_pipe_pkg.sv
// Shared types and defaults for the execute-to-CDB pipe.
// Holds lane/port/latency defaults, entry and packet layouts.
package ex_cdb_pipe_pkg;

  localparam int EX_N_LANES = 2;
  localparam int EX_N_CDB   = 1;
  localparam int EX_LAT     = 3;
  localparam int EX_TAG_W   = 6;
  localparam int EX_DATA_W  = 32;
  localparam int EX_LANE_W  = $clog2(EX_N_LANES);

  typedef struct packed {
    logic                 valid;
    logic [EX_TAG_W-1:0]  tag;
    logic [EX_DATA_W-1:0] data;
  } EX_PIPE_ENTRY;

  typedef struct packed {
    logic                 valid;
    logic [EX_TAG_W-1:0]  tag;
    logic [EX_DATA_W-1:0] data;
    logic [EX_LANE_W-1:0] lane;
  } CDB_PACKET;

  // v is always < 2*n here, so one subtract is a full modulo.
  function automatic int ex_wrap(
    input int v,
    input int n
  );
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/ex_cdb_pipe_rr_multi_grant.sv
// Round-robin arbiter granting up to N_GNT of N_REQ requests.
// Ports: req_i, ptr_i (scan start) -> gnt_o (one-hot/port), granted_o.
module rr_multi_grant
  import ex_cdb_pipe_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int N_GNT = 1,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]            req_i,
  input  logic [PW-1:0]               ptr_i,
  output logic [N_GNT-1:0][N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0]            granted_o
);

  // Scan from ptr_i; the n-th requester found takes port n.
  always_comb begin
    int n;
    gnt_o     = '0;
    granted_o = '0;
    n         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (j == ex_wrap(int'(ptr_i) + i, N_REQ)
            && req_i[j] && n < N_GNT) begin
          for (int k = 0; k < N_GNT; k++) begin
            if (k == n) gnt_o[k][j] = 1'b1;
          end
          granted_o[j] = 1'b1;
          n = n + 1;
        end
      end
    end
  end

endmodule

// File: rtl/ex_cdb_pipe.sv
// Fixed-latency execute lanes draining onto N_CDB broadcast ports.
// Ports: clock/reset/flush, issue_* (valid/tag/data/ready),
// cdb_* (valid/tag/data/lane per port), inflight_count.
module ex_cdb_pipe
  import ex_cdb_pipe_pkg::*;
#(
  parameter int N_LANES = EX_N_LANES,
  parameter int N_CDB   = EX_N_CDB,
  parameter int LAT     = EX_LAT,
  parameter int TAG_W   = EX_TAG_W,
  parameter int DATA_W  = EX_DATA_W,
  parameter int LW      = (N_LANES > 1) ? $clog2(N_LANES) : 1,
  parameter int CW      = $clog2(N_LANES * LAT + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N_LANES-1:0]        issue_valid,
  input  logic [N_LANES*TAG_W-1:0]  issue_tag,
  input  logic [N_LANES*DATA_W-1:0] issue_data,
  output logic [N_LANES-1:0]        issue_ready,
  output logic [N_CDB-1:0]          cdb_valid,
  output logic [N_CDB*TAG_W-1:0]    cdb_tag,
  output logic [N_CDB*DATA_W-1:0]   cdb_data,
  output logic [N_CDB*LW-1:0]       cdb_lane,
  output logic [CW-1:0]             inflight_count
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t st_q [N_LANES][LAT];

  logic [N_LANES-1:0]            out_v;
  logic [N_LANES-1:0]            zero_t;
  logic [N_LANES-1:0]            req;
  logic [N_LANES-1:0]            granted;
  logic [N_LANES-1:0]            adv;
  logic [N_CDB-1:0][N_LANES-1:0] gnt;
  logic [LW-1:0]                 rr_q;
  logic [LW-1:0]                 rr_d;

  // Tag-0 results have no consumer and leave without a port.
  always_comb begin
    out_v  = '0;
    zero_t = '0;
    req    = '0;
    adv    = '0;
    for (int l = 0; l < N_LANES; l++) begin
      out_v[l]  = st_q[l][LAT-1].valid;
      zero_t[l] = out_v[l]
                  && (st_q[l][LAT-1].tag == '0);
      req[l]    = out_v[l] && !zero_t[l] && !flush;
      adv[l]    = !out_v[l] || granted[l] || zero_t[l];
    end
  end

  assign issue_ready = adv & {N_LANES{!flush}};

  rr_multi_grant #(
    .N_REQ (N_LANES),
    .N_GNT (N_CDB),
    .PW    (LW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .granted_o (granted)
  );

  // Higher ports hold later lanes in scan order; last one wins.
  always_comb begin
    rr_d = rr_q;
    for (int k = 0; k < N_CDB; k++) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (gnt[k][l]) rr_d = LW'(ex_wrap(l + 1, N_LANES));
      end
    end
  end

  always_comb begin
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
    cdb_lane  = '0;
    for (int k = 0; k < N_CDB; k++) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (gnt[k][l]) begin
          cdb_valid[k] = 1'b1;
          cdb_tag[k*TAG_W +: TAG_W] = st_q[l][LAT-1].tag;
          cdb_data[k*DATA_W +: DATA_W] = st_q[l][LAT-1].data;
          cdb_lane[k*LW +: LW] = LW'(l);
        end
      end
    end
  end

  always_comb begin
    inflight_count = '0;
    for (int l = 0; l < N_LANES; l++) begin
      for (int s = 0; s < LAT; s++) begin
        inflight_count = inflight_count
                         + CW'(st_q[l][s].valid);
      end
    end
  end

  // Only valid bits are cleared; payloads are masked by valid.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int l = 0; l < N_LANES; l++) begin
        for (int s = 0; s < LAT; s++) begin
          st_q[l][s].valid <= 1'b0;
        end
      end
      rr_q <= '0;
    end else begin
      for (int l = 0; l < N_LANES; l++) begin
        if (adv[l]) begin
          for (int s = LAT - 1; s > 0; s--) begin
            st_q[l][s] <= st_q[l][s-1];
          end
          st_q[l][0] <= '{
            valid: issue_valid[l],
            tag:   issue_tag[l*TAG_W +: TAG_W],
            data:  issue_data[l*DATA_W +: DATA_W]
          };
        end
      end
      rr_q <= rr_d;
    end
  end

endmodule

// File: tb/tb_ex_cdb_pipe.sv
// Scoreboard bench for ex_cdb_pipe: one-port and two-port instances.
// Stimulus pushes expected broadcasts; negedge monitors pop and compare.
module tb_ex_cdb_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic armed = 1'b0;

  logic        ra, fa;
  logic [1:0]  a_iv, a_ir;
  logic [11:0] a_it;
  logic [63:0] a_id;
  logic [0:0]  a_cv, a_cl;
  logic [5:0]  a_ct;
  logic [31:0] a_cd;
  logic [2:0]  a_cnt;

  logic        rb, fb;
  logic [1:0]  b_iv, b_ir, b_cv, b_cl;
  logic [11:0] b_it, b_ct;
  logic [63:0] b_id, b_cd;
  logic [2:0]  b_cnt;

  ex_cdb_pipe #(
    .N_LANES(2), .N_CDB(1), .LAT(3),
    .TAG_W(6), .DATA_W(32)
  ) dut_a (
    .clock(clock), .reset(ra), .flush(fa),
    .issue_valid(a_iv), .issue_tag(a_it),
    .issue_data(a_id), .issue_ready(a_ir),
    .cdb_valid(a_cv), .cdb_tag(a_ct),
    .cdb_data(a_cd), .cdb_lane(a_cl),
    .inflight_count(a_cnt)
  );

  ex_cdb_pipe #(
    .N_LANES(2), .N_CDB(2), .LAT(3),
    .TAG_W(6), .DATA_W(32)
  ) dut_b (
    .clock(clock), .reset(rb), .flush(fb),
    .issue_valid(b_iv), .issue_tag(b_it),
    .issue_data(b_id), .issue_ready(b_ir),
    .cdb_valid(b_cv), .cdb_tag(b_ct),
    .cdb_data(b_cd), .cdb_lane(b_cl),
    .inflight_count(b_cnt)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    int          lane;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d",
               nm, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] t,
                              input logic [31:0] d,
                              input int l,
                              input int c);
    exp_t e;
    e.tag  = t;
    e.data = d;
    e.lane = l;
    e.cyc  = c;
    return e;
  endfunction

  always @(negedge clock) begin
    if (armed && !ra && a_cv[0]) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra tag=%0d cyc=%0d want none",
                 a_ct, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_tag", 64'(a_ct), 64'(ea.tag));
        chk("a_data", 64'(a_cd), 64'(ea.data));
        chk("a_lane", 64'(a_cl), 64'(ea.lane));
        chk("a_cyc", 64'(cyc), 64'(ea.cyc));
      end
    end
  end

  always @(negedge clock) begin
    if (armed && !rb) begin
      for (int k = 0; k < 2; k++) begin
        if (b_cv[k]) begin
          if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_extra port=%0d cyc=%0d want none",
                     k, cyc);
          end else begin
            eb = qb.pop_front();
            chk("b_tag", 64'(b_ct[k*6 +: 6]), 64'(eb.tag));
            chk("b_data", 64'(b_cd[k*32 +: 32]), 64'(eb.data));
            chk("b_lane", 64'(b_cl[k]), 64'(eb.lane));
            chk("b_cyc", 64'(cyc), 64'(eb.cyc));
          end
        end
      end
    end
  end

  task automatic da(input logic [1:0] v,
                    input logic [5:0] t0,
                    input logic [31:0] d0,
                    input logic [5:0] t1,
                    input logic [31:0] d1,
                    input logic f);
    a_iv = v;
    a_it = {t1, t0};
    a_id = {d1, d0};
    fa   = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    ra = 1'b1;
    rb = 1'b1;
    fb = 1'b0;
    b_iv = '0;
    b_it = '0;
    b_id = '0;
    da(2'b00, 0, 0, 0, 0, 1'b0);
    tick();
    tick();
    ra = 1'b0;
    rb = 1'b0;
    armed = 1'b1;

    // reset state
    @(negedge clock);
    chk("rst_a_cv", 64'(a_cv), 0);
    chk("rst_a_cnt", 64'(a_cnt), 0);
    chk("rst_a_rdy", 64'(a_ir), 3);
    chk("rst_b_cv", 64'(b_cv), 0);
    chk("rst_b_rdy", 64'(b_ir), 3);
    tick();

    // both lanes, ptr=0: lane0 first, lane1 held a cycle
    c = cyc;
    da(2'b11, 7, 32'h70, 9, 32'h90, 1'b0);
    qa.push_back(mk(7, 32'h70, 0, c + 3));
    qa.push_back(mk(9, 32'h90, 1, c + 4));
    @(negedge clock);
    chk("t2_rdy0", 64'(a_ir), 3);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    idle(2);
    @(negedge clock);
    chk("t2_hold", 64'(a_ir), 2'b01);
    chk("t2_cnt3", 64'(a_cnt), 2);
    tick();
    @(negedge clock);
    chk("t2_cnt4", 64'(a_cnt), 1);
    chk("t2_rdy4", 64'(a_ir), 3);
    tick();
    @(negedge clock);
    chk("t2_cnt5", 64'(a_cnt), 0);
    tick();

    // single entry latency and count
    c = cyc;
    da(2'b01, 5, 32'hAA, 0, 0, 1'b0);
    qa.push_back(mk(5, 32'hAA, 0, c + 3));
    @(negedge clock);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk("t1_cnt", 64'(a_cnt), (i <= 3) ? 1 : 0);
      tick();
    end

    // tag 0 drains silently, ready never drops
    da(2'b01, 0, 32'hBB, 0, 0, 1'b0);
    @(negedge clock);
    chk("t3_rdy0", 64'(a_ir[0]), 1);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk("t3_rdy", 64'(a_ir[0]), 1);
      chk("t3_cnt", 64'(a_cnt), (i <= 3) ? 1 : 0);
      tick();
    end

    // ptr=1 now: lane1 must win the tie
    c = cyc;
    da(2'b11, 11, 32'hB0, 12, 32'hC0, 1'b0);
    qa.push_back(mk(12, 32'hC0, 1, c + 3));
    qa.push_back(mk(11, 32'hB0, 0, c + 4));
    @(negedge clock);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    idle(5);

    // flush with 4 in flight, issue during flush is dropped
    da(2'b11, 20, 32'h20, 21, 32'h21, 1'b0);
    @(negedge clock);
    tick();
    da(2'b11, 22, 32'h22, 23, 32'h23, 1'b0);
    @(negedge clock);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    @(negedge clock);
    tick();
    da(2'b11, 24, 32'h24, 25, 32'h25, 1'b1);
    @(negedge clock);
    chk("fl_cv", 64'(a_cv), 0);
    chk("fl_rdy", 64'(a_ir), 0);
    chk("fl_cnt", 64'(a_cnt), 4);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    @(negedge clock);
    chk("fl_cnt_after", 64'(a_cnt), 0);
    chk("fl_rdy_after", 64'(a_ir), 3);
    tick();
    idle(6);

    // reset mid-stream with ptr=1 and 3 in flight
    c = cyc;
    da(2'b01, 30, 32'h30, 0, 0, 1'b0);
    qa.push_back(mk(30, 32'h30, 0, c + 3));
    @(negedge clock);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    @(negedge clock);
    tick();
    da(2'b11, 31, 32'h31, 32, 32'h32, 1'b0);
    @(negedge clock);
    tick();
    da(2'b01, 33, 32'h33, 0, 0, 1'b0);
    @(negedge clock);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    ra = 1'b1;
    @(negedge clock);
    chk("rs_cnt_pre", 64'(a_cnt), 3);
    tick();
    ra = 1'b0;
    c = cyc;
    da(2'b11, 34, 32'h34, 35, 32'h35, 1'b0);
    qa.push_back(mk(34, 32'h34, 0, c + 3));
    qa.push_back(mk(35, 32'h35, 1, c + 4));
    @(negedge clock);
    chk("rs_cv", 64'(a_cv), 0);
    chk("rs_tag", 64'(a_ct), 0);
    chk("rs_data", 64'(a_cd), 0);
    chk("rs_lane", 64'(a_cl), 0);
    chk("rs_cnt", 64'(a_cnt), 0);
    chk("rs_rdy", 64'(a_ir), 3);
    tick();
    da(2'b00, 0, 0, 0, 0, 1'b0);
    idle(7);

    // two ports, both lanes saturated
    c = cyc;
    for (int i = 0; i < 8; i++) begin
      b_iv = 2'b11;
      b_it = {6'(41 + 2 * i), 6'(40 + 2 * i)};
      b_id = {32'(32'h200 + i), 32'(32'h100 + i)};
      qb.push_back(mk(6'(40 + 2 * i), 32'h100 + i, 0, c + i + 3));
      qb.push_back(mk(6'(41 + 2 * i), 32'h200 + i, 1, c + i + 3));
      @(negedge clock);
      chk("b_rdy", 64'(b_ir), 3);
      if (i >= 3) chk("b_cnt", 64'(b_cnt), 6);
      tick();
    end
    b_iv = 2'b00;
    idle(6);

    chk("qa_empty", 64'(qa.size()), 0);
    chk("qb_empty", 64'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
